// File: rtl/systolic_array_ctrl_pkg.sv
// Shared types and defaults for the systolic array sequencer.
package systolic_array_ctrl_pkg;

    localparam int unsigned DEF_ARRAY_DIM = 8;
    localparam int unsigned DEF_CNT_W     = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/systolic_array_ctrl_valid_delay_line.sv
// Shift register that tracks activation-valid bits through the PE array.
module valid_delay_line #(
    parameter int unsigned DEPTH = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic din,
    output logic dout,
    output logic empty
);

    logic [DEPTH-1:0] stages;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stages <= '0;
        end else if (clear) begin
            stages <= '0;
        end else begin
            stages <= {stages[DEPTH-2:0], din};
        end
    end

    assign dout = stages[DEPTH-1];
    // Empty once nothing remains behind the output tap, so the bit now at
    // dout is the last one and the sequencer can leave DRAIN this cycle.
    assign empty = !din && (stages[DEPTH-2:0] == '0);

endmodule

// File: rtl/systolic_array_ctrl.sv
// Weight-stationary PE array sequencer: weight load, activation feed, drain.
module systolic_array_ctrl
    import systolic_array_ctrl_pkg::*;
#(
    parameter int unsigned ARRAY_DIM = DEF_ARRAY_DIM,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned PIPE_LAT  = 2 * ARRAY_DIM
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [CNT_W-1:0]             num_vecs,
    output logic                         busy,
    output logic                         done,
    output logic                         w_rd_en,
    output logic [$clog2(ARRAY_DIM)-1:0] w_rd_addr,
    output logic                         wen,
    output logic                         a_rd_en,
    output logic [CNT_W-1:0]             a_rd_addr,
    output logic                         a_valid,
    output logic                         out_valid,
    output logic [CNT_W-1:0]             out_addr
);

    localparam int unsigned       AW      = $clog2(ARRAY_DIM);
    localparam logic [AW-1:0]     W_FIRST = AW'(ARRAY_DIM - 1);
    localparam logic [AW-1:0]     W_ONE   = AW'(1);
    localparam logic [CNT_W-1:0]  C_ONE   = CNT_W'(1);

    state_t            state, state_next;
    logic [AW-1:0]     wcnt;
    logic [CNT_W-1:0]  nvecs;
    logic [CNT_W-1:0]  acnt;
    logic [CNT_W-1:0]  ocnt;
    logic              wen_q;
    logic              av_q;
    logic              kill;
    logic              dl_empty;

    assign kill = abort && (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:   if (start) state_next = ST_LOAD_W;
            ST_LOAD_W: if (wcnt == '0) state_next = (nvecs == '0) ? ST_DONE : ST_FEED;
            ST_FEED:   if (acnt == nvecs - C_ONE) state_next = ST_DRAIN;
            ST_DRAIN:  if (dl_empty) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        if (kill) state_next = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt  <= '0;
            nvecs <= '0;
            acnt  <= '0;
            ocnt  <= '0;
            wen_q <= 1'b0;
            av_q  <= 1'b0;
        end else if (kill) begin
            wcnt  <= '0;
            nvecs <= '0;
            acnt  <= '0;
            ocnt  <= '0;
            wen_q <= 1'b0;
            av_q  <= 1'b0;
        end else begin
            wen_q <= w_rd_en;
            av_q  <= a_rd_en;
            if (state == ST_IDLE && start) begin
                nvecs <= num_vecs;
                wcnt  <= W_FIRST;
                acnt  <= '0;
                ocnt  <= '0;
            end
            if (state == ST_LOAD_W && wcnt != '0) begin
                wcnt <= wcnt - W_ONE;
            end
            // Hold on the last address so num_vecs = all-ones never wraps.
            if (state == ST_FEED && acnt != nvecs - C_ONE) begin
                acnt <= acnt + C_ONE;
            end
            if (out_valid) begin
                ocnt <= ocnt + C_ONE;
            end
        end
    end

    valid_delay_line #(
        .DEPTH(PIPE_LAT)
    ) u_delay (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (kill),
        .din    (av_q),
        .dout   (out_valid),
        .empty  (dl_empty)
    );

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign w_rd_en   = (state == ST_LOAD_W);
    assign a_rd_en   = (state == ST_FEED);
    assign w_rd_addr = wcnt;
    assign a_rd_addr = acnt;
    assign out_addr  = ocnt;
    assign wen       = wen_q;
    assign a_valid   = av_q;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl with ARRAY_DIM=8, CNT_W=10.
module tb_systolic_array_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [9:0] num_vecs = '0;
    logic       busy, done, w_rd_en, wen, a_rd_en, a_valid, out_valid;
    logic [2:0] w_rd_addr;
    logic [9:0] a_rd_addr, out_addr;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       w_rd_en;
        logic [2:0] w_rd_addr;
        logic       wen;
        logic       a_rd_en;
        logic [9:0] a_rd_addr;
        logic       a_valid;
        logic       out_valid;
        logic [9:0] out_addr;
    } obs_t;

    systolic_array_ctrl #(
        .ARRAY_DIM(8),
        .CNT_W    (10)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .abort    (abort),
        .num_vecs (num_vecs),
        .busy     (busy),
        .done     (done),
        .w_rd_en  (w_rd_en),
        .w_rd_addr(w_rd_addr),
        .wen      (wen),
        .a_rd_en  (a_rd_en),
        .a_rd_addr(a_rd_addr),
        .a_valid  (a_valid),
        .out_valid(out_valid),
        .out_addr (out_addr)
    );

    always #5 clk = ~clk;

    // Addresses are only meaningful while their strobe is high.
    function automatic obs_t sample();
        obs_t s;
        s.busy      = busy;
        s.done      = done;
        s.w_rd_en   = w_rd_en;
        s.w_rd_addr = w_rd_en ? w_rd_addr : 3'd0;
        s.wen       = wen;
        s.a_rd_en   = a_rd_en;
        s.a_rd_addr = a_rd_en ? a_rd_addr : 10'd0;
        s.a_valid   = a_valid;
        s.out_valid = out_valid;
        s.out_addr  = out_valid ? out_addr : 10'd0;
        return s;
    endfunction

    // Expected outputs at cycle c of a job whose start was sampled in cycle 0.
    function automatic obs_t model(int n, int c);
        obs_t e;
        int   done_c;
        e      = '0;
        done_c = (n == 0) ? 9 : 26 + n;
        e.busy = (c >= 1 && c <= done_c);
        e.done = (c == done_c);
        if (c >= 1 && c <= 8) begin
            e.w_rd_en   = 1'b1;
            e.w_rd_addr = 3'(8 - c);
        end
        e.wen = (c >= 2 && c <= 9);
        if (n > 0 && c >= 9 && c <= 8 + n) begin
            e.a_rd_en   = 1'b1;
            e.a_rd_addr = 10'(c - 9);
        end
        e.a_valid = (n > 0 && c >= 10 && c <= 9 + n);
        if (n > 0 && c >= 26 && c <= 25 + n) begin
            e.out_valid = 1'b1;
            e.out_addr  = 10'(c - 26);
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t o;
        tick();
        tick();
        o = sample();
        checks++;
        if (o !== obs_t'('0)) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", o, obs_t'('0));
        end
        checks++;
        if (out_addr !== 10'd0 || a_rd_addr !== 10'd0 || w_rd_addr !== 3'd0) begin
            errors++;
            $display("FAIL reset_addrs got=%h/%h/%h exp=0/0/0", out_addr, a_rd_addr, w_rd_addr);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_feed();
        obs_t o, e;
        start = 1'b1;
        num_vecs = 10'd4;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0;
            o = sample();
            e = model(4, c);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rst_pre c=%0d got=%h exp=%h", c, o, e);
            end
        end
        #2 reset_n = 1'b0;
        #1;
        o = sample();
        checks++;
        if (o !== obs_t'('0) || a_rd_addr !== 10'd0) begin
            errors++;
            $display("FAIL rst_async got=%h addr=%0d exp=0", o, a_rd_addr);
        end
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            o = sample();
            checks++;
            if (o !== obs_t'('0)) begin
                errors++;
                $display("FAIL rst_after c=%0d got=%h exp=0", c, o);
            end
        end
    endtask

    task automatic test_basic();
        obs_t o, e;
        start = 1'b1;
        num_vecs = 10'd4;
        for (int c = 1; c <= 34; c++) begin
            tick();
            start = 1'b0;
            o = sample();
            e = model(4, c);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL basic c=%0d got=%h exp=%h", c, o, e);
            end
            checks++;
            if (wen && a_valid) begin
                errors++;
                $display("FAIL basic_overlap c=%0d got wen=1 a_valid=1 exp not both", c);
            end
        end
    endtask

    task automatic test_zero_vecs();
        obs_t o, e;
        start = 1'b1;
        num_vecs = 10'd0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            start = 1'b0;
            o = sample();
            e = model(0, c);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL zero c=%0d got=%h exp=%h", c, o, e);
            end
        end
    endtask

    task automatic test_start_while_busy();
        obs_t o, e;
        int   n_done = 0;
        int   n_ov = 0;
        start = 1'b1;
        num_vecs = 10'd3;
        for (int c = 1; c <= 36; c++) begin
            tick();
            start    = (c == 5 || c == 15 || c == 27);
            num_vecs = start ? 10'd7 : 10'd3;
            o = sample();
            e = model(3, c);
            if (c >= 30) e = '0;
            n_done += int'(done);
            n_ov   += int'(out_valid);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL busy_start c=%0d got=%h exp=%h", c, o, e);
            end
        end
        start = 1'b0;
        checks++;
        if (n_done != 1 || n_ov != 3) begin
            errors++;
            $display("FAIL busy_start_counts got done=%0d ov=%0d exp done=1 ov=3", n_done, n_ov);
        end
    endtask

    task automatic test_abort();
        obs_t o, e;
        start = 1'b1;
        num_vecs = 10'd4;
        for (int c = 1; c <= 40; c++) begin
            tick();
            start = 1'b0;
            abort = (c == 11);
            o = sample();
            e = (c <= 11) ? model(4, c) : obs_t'('0);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL abort c=%0d got=%h exp=%h", c, o, e);
            end
        end
        start = 1'b1;
        num_vecs = 10'd2;
        for (int c = 1; c <= 32; c++) begin
            tick();
            start = 1'b0;
            o = sample();
            e = model(2, c);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL abort_rerun c=%0d got=%h exp=%h", c, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        int   n_ov = 0;
        start = 1'b1;
        num_vecs = 10'd1;
        for (int c = 1; c <= 27; c++) begin
            tick();
            start = 1'b0;
            o = sample();
            e = model(1, c);
            n_ov += int'(out_valid);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL b2b_first c=%0d got=%h exp=%h", c, o, e);
            end
        end
        tick();
        start = 1'b1;
        num_vecs = 10'd2;
        o = sample();
        checks++;
        if (o !== obs_t'('0)) begin
            errors++;
            $display("FAIL b2b_idle got=%h exp=0", o);
        end
        for (int c = 1; c <= 32; c++) begin
            tick();
            start = 1'b0;
            o = sample();
            e = model(2, c);
            n_ov += int'(out_valid);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL b2b_second c=%0d got=%h exp=%h", c, o, e);
            end
        end
        checks++;
        if (n_ov != 3) begin
            errors++;
            $display("FAIL b2b_ov_count got=%0d exp=3", n_ov);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_feed();
        test_basic();
        test_zero_vecs();
        test_start_while_busy();
        test_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
